// File: rtl/nios_system_timer_pkg.sv
// Shared register-map constants and the per-channel write strobe bundle
// for the multi-channel interval timer.
package nios_system_timer_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_SNAPSHOT = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snapshot;
    logic prescale;
  } wr_strobe_t;

endpackage

// File: rtl/nios_system_timer_channel.sv
// One timer channel: prescaler, down-counter, TO/RUN flags, control,
// period and snapshot registers, plus its own read mux.
module nios_system_timer_channel
  import nios_system_timer_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter int               PRE_W       = 16,
  parameter int               DATA_W      = 32,
  parameter logic [CNT_W-1:0] PERIOD_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  wr_strobe_t        wr,
  input  logic [DATA_W-1:0] writedata,
  input  logic [2:0]        rd_off,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] snap;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       control;
  logic             run;
  logic             to;
  logic             tick;
  logic             expire;

  assign tick   = run && (pre_cnt == prescale);
  assign expire = tick && (count == '0);

  // Register writes are applied after the counting update so that software
  // wins over the counter, except that a timeout beats a STATUS clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= PERIOD_INIT;
      period   <= PERIOD_INIT;
      snap     <= '0;
      prescale <= '0;
      pre_cnt  <= '0;
      control  <= '0;
      run      <= 1'b0;
      to       <= 1'b0;
    end else begin
      if (run) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        if (count == '0) begin
          count <= period;
          to    <= 1'b1;
          if (!control[CTL_CONT]) run <= 1'b0;
        end else begin
          count <= count - 1'b1;
        end
      end
      if (wr.status && !expire) to <= 1'b0;
      if (wr.control) begin
        control <= writedata[3:0];
        if (writedata[CTL_START]) begin
          run     <= 1'b1;
          pre_cnt <= '0;
        end else if (writedata[CTL_STOP]) begin
          run <= 1'b0;
        end
      end
      if (wr.period) begin
        period  <= writedata[CNT_W-1:0];
        count   <= writedata[CNT_W-1:0];
        run     <= 1'b0;
        pre_cnt <= '0;
      end
      if (wr.snapshot) snap <= count;
      if (wr.prescale) begin
        prescale <= writedata[PRE_W-1:0];
        pre_cnt  <= '0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_off)
      OFF_STATUS:   rdata[1:0]       = {run, to};
      OFF_CONTROL:  rdata[3:0]       = control;
      OFF_PERIOD:   rdata[CNT_W-1:0] = period;
      OFF_SNAPSHOT: rdata[CNT_W-1:0] = snap;
      OFF_PRESCALE: rdata[PRE_W-1:0] = prescale;
      default:      rdata            = '0;
    endcase
  end

  assign irq = to & control[CTL_ITO];

endmodule

// File: rtl/nios_system_multi_timer.sv
// Multi-channel interval timer, Avalon-MM slave: address decode, channel
// array, registered read data and combined interrupt.
module nios_system_multi_timer
  import nios_system_timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 16,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] PERIOD_RST = 32'h1DCD64FF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_CH)+2:0]    address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic                         read_n,
  input  logic [DATA_W-1:0]            writedata,
  output logic [DATA_W-1:0]            readdata,
  output logic                         irq,
  output logic [NUM_CH-1:0]            irq_vec
);

  localparam int               AW          = $clog2(NUM_CH) + 3;
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);

  logic              wr_en;
  logic [2:0]        offset;
  logic [AW-1:0]     ch_idx;
  logic [DATA_W-1:0] ch_rdata [NUM_CH];
  logic [DATA_W-1:0] rd_next;
  logic              unused_read;

  // Read data is produced every cycle, so the read strobe carries no information.
  assign unused_read = read_n;
  assign wr_en       = chipselect & ~write_n;
  assign offset      = address[2:0];
  assign ch_idx      = address >> 3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wr_strobe_t strobe;

    always_comb begin
      strobe = '0;
      if (wr_en && (ch_idx == AW'(g))) begin
        case (offset)
          OFF_STATUS:   strobe.status   = 1'b1;
          OFF_CONTROL:  strobe.control  = 1'b1;
          OFF_PERIOD:   strobe.period   = 1'b1;
          OFF_SNAPSHOT: strobe.snapshot = 1'b1;
          OFF_PRESCALE: strobe.prescale = 1'b1;
          default:      strobe          = '0;
        endcase
      end
    end

    nios_system_timer_channel #(
      .CNT_W       (CNT_W),
      .PRE_W       (PRE_W),
      .DATA_W      (DATA_W),
      .PERIOD_INIT (PERIOD_INIT)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .wr        (strobe),
      .writedata (writedata),
      .rd_off    (offset),
      .rdata     (ch_rdata[g]),
      .irq       (irq_vec[g])
    );
  end

  // Channel indices with no instance fall through to zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == AW'(i)) rd_next = ch_rdata[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign irq = |irq_vec;

endmodule
